code25_rx: RTL and testbench

CODE25_RX -- requirements
Module: code25_rx

---
 rtl/code25_rx.sv | 169 ++++++++++++++++
 tb/tb_code25_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/code25_rx.sv
// Serial 2-of-5 code receiver: decodes 5-bit symbols (MSB first) into BCD digits
// and assembles DIGITS of them into a number held until the consumer acknowledges it.
module code25_rx #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_vld,
  input  logic                  sync,
  input  logic                  num_ack,
  output logic [3:0]            digit,
  output logic                  digit_vld,
  output logic                  sym_err,
  output logic [4*DIGITS-1:0]   number,
  output logic                  num_vld,
  output logic                  ovr
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  // Returns {legal, bcd}; any code without exactly two ones is illegal.
  function automatic logic [4:0] code25_decode(input logic [4:0] sym);
    logic [4:0] res;
    case (sym)
      5'b11000: res = 5'b1_0000;
      5'b00011: res = 5'b1_0001;
      5'b00101: res = 5'b1_0010;
      5'b00110: res = 5'b1_0011;
      5'b01001: res = 5'b1_0100;
      5'b01010: res = 5'b1_0101;
      5'b01100: res = 5'b1_0110;
      5'b10001: res = 5'b1_0111;
      5'b10010: res = 5'b1_1000;
      5'b10100: res = 5'b1_1001;
      default:  res = 5'b0_0000;
    endcase
    return res;
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          bit_cnt_r, bit_cnt_s;
  // Only the first four bits need storing; the fifth feeds the decoder directly.
  logic [3:0]          sym_r, sym_s;
  logic [3:0]          dig_cnt_r, dig_cnt_s;
  logic [3:0]          digit_r, digit_s;
  logic [4*DIGITS-1:0] number_r, number_s;
  logic                digit_vld_r, digit_vld_s;
  logic                sym_err_r, sym_err_s;
  logic                num_vld_r, num_vld_s;
  logic                ovr_r, ovr_s;

  logic [3:0]          sym_base_s;
  logic [2:0]          cnt_base_s;
  logic [4:0]          full_sym_s;
  logic [4:0]          dec_s;
  logic [4*DIGITS-1:0] shifted_s;
  logic [3:0]          dig_inc_s;

  // Next-state and next-output computation for the receiver.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    sym_s       = sym_r;
    dig_cnt_s   = dig_cnt_r;
    digit_s     = digit_r;
    number_s    = number_r;
    num_vld_s   = num_vld_r;
    digit_vld_s = 1'b0;
    sym_err_s   = 1'b0;
    ovr_s       = 1'b0;

    // sync restarts the symbol; a bit arriving with it becomes bit 1.
    sym_base_s  = sync ? 4'd0 : sym_r;
    cnt_base_s  = sync ? 3'd0 : bit_cnt_r;
    full_sym_s  = {sym_base_s, bit_in};
    dec_s       = code25_decode(full_sym_s);
    shifted_s   = number_r << 3'd4;
    shifted_s[3:0] = dec_s[3:0];
    dig_inc_s   = dig_cnt_r + 4'd1;

    case (state_r)
      COLLECT: begin
        if (bit_vld) begin
          if (cnt_base_s == 3'd4) begin
            bit_cnt_s = 3'd0;
            sym_s     = 4'd0;
            if (dec_s[4]) begin
              digit_s     = dec_s[3:0];
              digit_vld_s = 1'b1;
              number_s    = shifted_s;
              dig_cnt_s   = dig_inc_s;
              if (dig_inc_s == DIGITS_C) begin
                num_vld_s = 1'b1;
                state_s   = HOLD;
              end else begin
                num_vld_s = 1'b0;
              end
            end else begin
              sym_err_s = 1'b1;
            end
          end else begin
            bit_cnt_s = cnt_base_s + 3'd1;
            sym_s     = full_sym_s[3:0];
          end
        end else if (sync) begin
          bit_cnt_s = 3'd0;
          sym_s     = 4'd0;
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      HOLD: begin
        ovr_s = bit_vld;
        if (num_ack) begin
          num_vld_s = 1'b0;
          number_s  = '0;
          dig_cnt_s = 4'd0;
          state_s   = COLLECT;
        end else begin
          num_vld_s = 1'b1;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      bit_cnt_r   <= 3'd0;
      sym_r       <= 4'd0;
      dig_cnt_r   <= 4'd0;
      digit_r     <= 4'd0;
      number_r    <= '0;
      digit_vld_r <= 1'b0;
      sym_err_r   <= 1'b0;
      num_vld_r   <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      sym_r       <= sym_s;
      dig_cnt_r   <= dig_cnt_s;
      digit_r     <= digit_s;
      number_r    <= number_s;
      digit_vld_r <= digit_vld_s;
      sym_err_r   <= sym_err_s;
      num_vld_r   <= num_vld_s;
      ovr_r       <= ovr_s;
    end
  end

  assign digit     = digit_r;
  assign digit_vld = digit_vld_r;
  assign sym_err   = sym_err_r;
  assign number    = number_r;
  assign num_vld   = num_vld_r;
  assign ovr       = ovr_r;

endmodule

// File: tb/tb_code25_rx.sv
// Directed self-checking bench for code25_rx (DIGITS=4): inputs change and
// outputs are sampled on the falling edge.
module tb_code25_rx;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_vld;
  logic        sync;
  logic        num_ack;
  logic [3:0]  digit;
  logic        digit_vld;
  logic        sym_err;
  logic [15:0] number;
  logic        num_vld;
  logic        ovr;

  int total;
  int bad;

  code25_rx #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .sync      (sync),
    .num_ack   (num_ack),
    .digit     (digit),
    .digit_vld (digit_vld),
    .sym_err   (sym_err),
    .number    (number),
    .num_vld   (num_vld),
    .ovr       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic dv, input logic se, input logic ov,
                         input logic nv, input logic [3:0] dg, input logic [15:0] nm);
    chk({tag, ".digit_vld"}, {31'd0, digit_vld}, {31'd0, dv});
    chk({tag, ".sym_err"},   {31'd0, sym_err},   {31'd0, se});
    chk({tag, ".ovr"},       {31'd0, ovr},       {31'd0, ov});
    chk({tag, ".num_vld"},   {31'd0, num_vld},   {31'd0, nv});
    chk({tag, ".digit"},     {28'd0, digit},     {28'd0, dg});
    chk({tag, ".number"},    {16'd0, number},    {16'd0, nm});
  endtask

  // Apply one cycle of inputs; returns at the next falling edge.
  task automatic cyc(input logic vld, input logic b, input logic sy, input logic ack);
    bit_vld = vld;
    bit_in  = b;
    sync    = sy;
    num_ack = ack;
    @(negedge clk);
    bit_vld = 1'b0;
    bit_in  = 1'b0;
    sync    = 1'b0;
    num_ack = 1'b0;
  endtask

  task automatic send_sym(input logic [4:0] s, input int gap);
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, s[i], 1'b0, 1'b0);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    sync    = 1'b0;
    num_ack = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);

    // Back-to-back 00101 decodes to 2 with a single-cycle pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("bit4.digit_vld", {31'd0, digit_vld}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_out("d2", 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 16'h0002);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("d2.pulse_end", {31'd0, digit_vld}, 32'd0);

    // Ack outside HOLD is ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("ack_collect", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'h0002);

    // Remaining digits 0,2,5 with idle gaps between bits.
    send_sym(5'b11000, 1);
    exp_out("d0", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0020);
    send_sym(5'b00101, 2);
    exp_out("d2b", 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 16'h0202);
    send_sym(5'b01010, 3);
    exp_out("d5_full", 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 16'h2025);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_out("hold_idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 16'h2025);

    // HOLD: dropped bit, then dropped bit together with ack.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_out("hold_ovr", 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 16'h2025);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_ovr.pulse_end", {31'd0, ovr}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    exp_out("ack_ovr", 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 16'h0000);
    send_sym(5'b00011, 0);
    exp_out("d1_after_ack", 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 16'h0001);

    // Illegal symbol after a good 7 leaves everything untouched.
    do_reset();
    send_sym(5'b10001, 0);
    exp_out("d7", 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 16'h0007);
    send_sym(5'b11100, 0);
    exp_out("illegal", 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 16'h0007);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("illegal.pulse_end", {31'd0, sym_err}, 32'd0);

    // Bits 1,1,0 then sync with a 0 bit, then 1,0,1,0 -> 01010 = 5.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_out("sync_bit", 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 16'h0075);

    // Sync alone mid-symbol, then 6 and 8; digit count shows the bad symbol was not counted.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    send_sym(5'b01100, 0);
    exp_out("d6", 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 16'h0756);
    send_sym(5'b10010, 1);
    exp_out("d8_full", 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 16'h7568);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("sync_hold", 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 16'h7568);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("ack", 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 16'h0000);

    // Reset with two stored digits and a partial symbol.
    send_sym(5'b01001, 0);
    send_sym(5'b00110, 0);
    chk("pre_rst.number", {16'd0, number}, 32'h0043);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    exp_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    send_sym(5'b10100, 0);
    exp_out("d9_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 16'h0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
